// File: rtl/pc_pkg.sv
// pc_pkg: shared encodings and defaults for the fetch PC sequencer.
// Holds br_op/jmp_op codes, reset/exception vectors and the buffer state type.
package pc_pkg;

    localparam int          PC_ADDR_W    = 32;
    localparam int          PC_JIDX_W    = 26;
    localparam logic [31:0] PC_RESET_VEC = 32'h0000_3000;
    localparam logic [31:0] PC_EXC_VEC   = 32'h0000_4180;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLEZ = 3'd3;
    localparam logic [2:0] BR_BGTZ = 3'd4;
    localparam logic [2:0] BR_BLTZ = 3'd5;
    localparam logic [2:0] BR_BGEZ = 3'd6;
    localparam logic [2:0] BR_RSVD = 3'd7;

    localparam logic [1:0] JMP_NONE = 2'd0;
    localparam logic [1:0] JMP_J    = 2'd1;
    localparam logic [1:0] JMP_JR   = 2'd2;
    localparam logic [1:0] JMP_RSVD = 2'd3;

    typedef enum logic {
        PEND_EMPTY,
        PEND_FULL
    } pend_e;

endpackage

// File: rtl/pc_sequencer_br_cmp.sv
// br_cmp: combinational branch-condition evaluator (signed 32-bit compares).
// Ports: br_op (branch code), br_a/br_b (forwarded rs/rt), taken (condition met).
module br_cmp
    import pc_pkg::*;
(
    input  logic [2:0]  br_op,
    input  logic [31:0] br_a,
    input  logic [31:0] br_b,
    output logic        taken
);

    logic a_eq_b;
    logic a_neg;
    logic a_zero;

    assign a_eq_b = (br_a == br_b);
    assign a_neg  = br_a[31];
    assign a_zero = (br_a == 32'd0);

    always_comb begin
        taken = 1'b0;
        unique case (1'b1)
            (br_op == BR_BEQ):  taken = a_eq_b;
            (br_op == BR_BNE):  taken = !a_eq_b;
            (br_op == BR_BLEZ): taken = a_neg || a_zero;
            (br_op == BR_BGTZ): taken = !a_neg && !a_zero;
            (br_op == BR_BLTZ): taken = a_neg;
            (br_op == BR_BGEZ): taken = !a_neg;
            default:            taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: F-stage PC register with branch/jump/exception/eret redirects
// and a one-entry pending-redirect buffer that survives F stalls.
// Ports: clk, reset (async, active-low), stall, br_op, jmp_op, br_a, br_b,
//   imm16, imm26, pc4_d, exc_req, eret_req, epc -> pc, pc4, redirect,
//   pend_valid; adel_pc only when PC_ALIGN_CHECK_EN is defined.
// Optional macro: PC_ALIGN_CHECK_EN (misaligned jr/eret target -> EXC_VEC).
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = PC_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(PC_RESET_VEC),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(PC_EXC_VEC),
    parameter int                JIDX_W    = PC_JIDX_W
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [2:0]        br_op,
    input  logic [1:0]        jmp_op,
    input  logic [31:0]       br_a,
    input  logic [31:0]       br_b,
    input  logic [15:0]       imm16,
    input  logic [JIDX_W-1:0] imm26,
    input  logic [ADDR_W-1:0] pc4_d,
    input  logic              exc_req,
    input  logic              eret_req,
    input  logic [ADDR_W-1:0] epc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc4,
    output logic              redirect,
    output logic              pend_valid
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic              adel_pc
`endif
);

    logic              taken;
    logic              is_j;
    logic              is_jr;
    logic              ctl_hit;
    logic [ADDR_W-1:0] imm_sext;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] j_tgt;
    logic [ADDR_W-1:0] jr_tgt;
    logic [ADDR_W-1:0] ctl_tgt;
    logic              eret_bad;
    logic              jr_bad;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] tgt_q;
    logic [ADDR_W-1:0] tgt_nxt;
    pend_e             pend_q;
    pend_e             pend_nxt;
    logic              redir_q;
    logic              redir_nxt;

    br_cmp u_br_cmp (
        .br_op (br_op),
        .br_a  (br_a),
        .br_b  (br_b),
        .taken (taken)
    );

    assign is_j     = (jmp_op == JMP_J);
    assign is_jr    = (jmp_op == JMP_JR);
    assign ctl_hit  = taken || is_j || is_jr;

    assign imm_sext = {{(ADDR_W-16){imm16[15]}}, imm16};
    assign br_tgt   = pc4_d + (imm_sext << 2);
    assign j_tgt    = {pc4_d[ADDR_W-1:JIDX_W+2], imm26, 2'b00};
    assign jr_tgt   = ADDR_W'(br_a);

    // A jump in D takes precedence over a branch code in the same slot.
    assign ctl_tgt  = is_jr ? jr_tgt :
                      is_j  ? j_tgt  : br_tgt;

`ifdef PC_ALIGN_CHECK_EN
    assign eret_bad = eret_req && (epc[1:0] != 2'b00);
    assign jr_bad   = is_jr && (jr_tgt[1:0] != 2'b00);
`else
    assign eret_bad = 1'b0;
    assign jr_bad   = 1'b0;
`endif

    assign pc4 = pc_q + ADDR_W'(4);

    always_comb begin
        pc_nxt    = pc4;
        tgt_nxt   = tgt_q;
        pend_nxt  = pend_q;
        redir_nxt = 1'b0;
        if (exc_req) begin
            pc_nxt    = EXC_VEC;
            pend_nxt  = PEND_EMPTY;
            redir_nxt = 1'b1;
        end else if (eret_req) begin
            pc_nxt    = eret_bad ? EXC_VEC : epc;
            pend_nxt  = PEND_EMPTY;
            redir_nxt = 1'b1;
        end else if (jr_bad) begin
            // Misaligned jr traps immediately, even under stall.
            pc_nxt    = EXC_VEC;
            pend_nxt  = PEND_EMPTY;
            redir_nxt = 1'b1;
        end else if (stall) begin
            pc_nxt = pc_q;
            if (ctl_hit) begin
                tgt_nxt  = ctl_tgt;
                pend_nxt = PEND_FULL;
            end
        end else if (ctl_hit) begin
            pc_nxt    = ctl_tgt;
            pend_nxt  = PEND_EMPTY;
            redir_nxt = 1'b1;
        end else if (pend_q == PEND_FULL) begin
            pc_nxt    = tgt_q;
            pend_nxt  = PEND_EMPTY;
            redir_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_VEC;
            tgt_q   <= '0;
            pend_q  <= PEND_EMPTY;
            redir_q <= 1'b0;
        end else begin
            pc_q    <= pc_nxt;
            tgt_q   <= tgt_nxt;
            pend_q  <= pend_nxt;
            redir_q <= redir_nxt;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic adel_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            adel_q <= 1'b0;
        end else begin
            adel_q <= !exc_req && (eret_req ? eret_bad : jr_bad);
        end
    end

    assign adel_pc = adel_q;
`endif

    assign pc         = pc_q;
    assign redirect   = redir_q;
    assign pend_valid = (pend_q == PEND_FULL);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer
// against a behavioural next-PC model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic [2:0]  br_op = 3'd0;
    logic [1:0]  jmp_op = 2'd0;
    logic [31:0] br_a = 32'd0;
    logic [31:0] br_b = 32'd0;
    logic [15:0] imm16 = 16'd0;
    logic [25:0] imm26 = 26'd0;
    logic [31:0] pc4_d = 32'd0;
    logic        exc_req = 1'b0;
    logic        eret_req = 1'b0;
    logic [31:0] epc = 32'd0;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        redirect;
    logic        pend_valid;
    logic        adel_pc;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc;
    logic [31:0] m_pt;
    logic        m_pv;
    logic        m_rd;
    logic        m_ad;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .br_op      (br_op),
        .jmp_op     (jmp_op),
        .br_a       (br_a),
        .br_b       (br_b),
        .imm16      (imm16),
        .imm26      (imm26),
        .pc4_d      (pc4_d),
        .exc_req    (exc_req),
        .eret_req   (eret_req),
        .epc        (epc),
        .pc         (pc),
        .pc4        (pc4),
        .redirect   (redirect),
        .pend_valid (pend_valid)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .adel_pc    (adel_pc)
`endif
    );

`ifndef PC_ALIGN_CHECK_EN
    assign adel_pc = 1'b0;
`endif

    task automatic model_reset();
        m_pc = 32'h0000_3000;
        m_pt = 32'd0;
        m_pv = 1'b0;
        m_rd = 1'b0;
        m_ad = 1'b0;
    endtask

    task automatic model_edge();
        bit          tk;
        bit          hit;
        bit          align_on;
        logic [31:0] tgt;
        int          off;
        if (!reset) begin
            model_reset();
            return;
        end
`ifdef PC_ALIGN_CHECK_EN
        align_on = 1'b1;
`else
        align_on = 1'b0;
`endif
        case (br_op)
            3'd1: tk = (br_a == br_b);
            3'd2: tk = (br_a != br_b);
            3'd3: tk = ($signed(br_a) <= 0);
            3'd4: tk = ($signed(br_a) > 0);
            3'd5: tk = ($signed(br_a) < 0);
            3'd6: tk = ($signed(br_a) >= 0);
            default: tk = 1'b0;
        endcase
        off = $signed(imm16);
        if (jmp_op == 2'd2)
            tgt = br_a;
        else if (jmp_op == 2'd1)
            tgt = (pc4_d & 32'hF000_0000) | (32'(imm26) * 4);
        else
            tgt = pc4_d + 32'(off * 4);
        hit = tk || jmp_op == 2'd1 || jmp_op == 2'd2;
        m_rd = 1'b0;
        m_ad = 1'b0;
        if (exc_req) begin
            m_pc = 32'h0000_4180; m_pv = 0; m_rd = 1;
        end else if (eret_req) begin
            if (align_on && epc % 4 != 0) begin
                m_pc = 32'h0000_4180; m_ad = 1;
            end else begin
                m_pc = epc;
            end
            m_pv = 0; m_rd = 1;
        end else if (align_on && jmp_op == 2'd2 && br_a % 4 != 0) begin
            m_pc = 32'h0000_4180; m_pv = 0; m_rd = 1; m_ad = 1;
        end else if (stall) begin
            if (hit) begin
                m_pt = tgt; m_pv = 1;
            end
        end else if (hit) begin
            m_pc = tgt; m_pv = 0; m_rd = 1;
        end else if (m_pv) begin
            m_pc = m_pt; m_pv = 0; m_rd = 1;
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_in();
        stall = 0; br_op = 0; jmp_op = 0; br_a = 0; br_b = 0;
        imm16 = 0; imm26 = 0; pc4_d = 0; exc_req = 0;
        eret_req = 0; epc = 0;
    endtask

    task automatic test_reset();
        clear_in();
        reset = 1'b0;
        model_reset();
        #12;
        checks++;
        if (pc !== 32'h3000 || pend_valid !== 1'b0 || redirect !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got pc=%h pv=%b rd=%b exp pc=3000 pv=0 rd=0",
                     pc, pend_valid, redirect);
        end
        @(negedge clk);
        reset = 1'b1;
        step();
        checks++;
        if (pc !== 32'h3004 || redirect !== 1'b0) begin
            errors++;
            $display("FAIL reset_seq1 got pc=%h rd=%b exp 3004 0", pc, redirect);
        end
        step();
        checks++;
        if (pc !== 32'h3008 || pc4 !== 32'h300C || redirect !== 1'b0) begin
            errors++;
            $display("FAIL reset_seq2 got pc=%h pc4=%h rd=%b exp 3008 300c 0",
                     pc, pc4, redirect);
        end
    endtask

    task automatic test_beq();
        br_op = 3'd1; br_a = 5; br_b = 5; pc4_d = 32'h3008; imm16 = 16'hFFFE;
        step();
        checks++;
        if (pc !== 32'h3000 || redirect !== 1'b1) begin
            errors++;
            $display("FAIL beq_taken got pc=%h rd=%b exp 3000 1", pc, redirect);
        end
        clear_in();
        step();
        checks++;
        if (pc !== 32'h3004 || redirect !== 1'b0) begin
            errors++;
            $display("FAIL beq_after got pc=%h rd=%b exp 3004 0", pc, redirect);
        end
    endtask

    task automatic test_stall_branch();
        stall = 1; br_op = 3'd4; br_a = 1; imm16 = 16'h0004; pc4_d = 32'h3010;
        step();
        checks++;
        if (pc !== 32'h3004 || pend_valid !== 1'b1 || redirect !== 1'b0) begin
            errors++;
            $display("FAIL stall_latch got pc=%h pv=%b rd=%b exp 3004 1 0",
                     pc, pend_valid, redirect);
        end
        br_op = 0; br_a = 0; imm16 = 0; pc4_d = 0;
        step();
        step();
        checks++;
        if (pc !== 32'h3004 || pend_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold got pc=%h pv=%b exp 3004 1", pc, pend_valid);
        end
        stall = 0;
        step();
        checks++;
        if (pc !== 32'h3020 || pend_valid !== 1'b0 || redirect !== 1'b1) begin
            errors++;
            $display("FAIL stall_release got pc=%h pv=%b rd=%b exp 3020 0 1",
                     pc, pend_valid, redirect);
        end
    endtask

    task automatic test_exc_eret();
        stall = 1; br_op = 3'd1; br_a = 7; br_b = 7; pc4_d = 32'h3100;
        step();
        br_op = 0;
        exc_req = 1;
        step();
        checks++;
        if (pc !== 32'h4180 || pend_valid !== 1'b0 || redirect !== 1'b1) begin
            errors++;
            $display("FAIL exc_entry got pc=%h pv=%b rd=%b exp 4180 0 1",
                     pc, pend_valid, redirect);
        end
        exc_req = 0; stall = 0; eret_req = 1; epc = 32'h3044;
        step();
        checks++;
        if (pc !== 32'h3044 || redirect !== 1'b1) begin
            errors++;
            $display("FAIL eret got pc=%h rd=%b exp 3044 1", pc, redirect);
        end
        clear_in();
    endtask

    task automatic test_jr_wrap();
        jmp_op = 2'd2; br_a = 32'hFFFF_FFFC;
        step();
        checks++;
        if (pc !== 32'hFFFF_FFFC || pc4 !== 32'h0 || redirect !== 1'b1) begin
            errors++;
            $display("FAIL jr_load got pc=%h pc4=%h rd=%b exp fffffffc 0 1",
                     pc, pc4, redirect);
        end
        clear_in();
        step();
        checks++;
        if (pc !== 32'h0 || redirect !== 1'b0) begin
            errors++;
            $display("FAIL pc_wrap got pc=%h rd=%b exp 0 0", pc, redirect);
        end
        imm26 = 26'h0000_C40; pc4_d = 32'hA000_0010; jmp_op = 2'd1;
        step();
        checks++;
        if (pc !== 32'hA000_3100) begin
            errors++;
            $display("FAIL j_target got pc=%h exp a0003100", pc);
        end
        clear_in();
    endtask

    task automatic test_align();
        jmp_op = 2'd2; br_a = 32'h3002;
        step();
`ifdef PC_ALIGN_CHECK_EN
        checks++;
        if (pc !== 32'h4180 || adel_pc !== 1'b1) begin
            errors++;
            $display("FAIL align_jr got pc=%h adel=%b exp 4180 1", pc, adel_pc);
        end
        clear_in();
        step();
        checks++;
        if (adel_pc !== 1'b0) begin
            errors++;
            $display("FAIL align_pulse got adel=%b exp 0", adel_pc);
        end
`else
        checks++;
        if (pc !== 32'h3002) begin
            errors++;
            $display("FAIL align_off got pc=%h exp 3002", pc);
        end
        clear_in();
        step();
`endif
    endtask

    task automatic test_reset_mid_stall();
        stall = 1; br_op = 3'd2; br_a = 1; br_b = 2; pc4_d = 32'h5000;
        imm16 = 16'h0010;
        step();
        checks++;
        if (pend_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_latch got pv=%b exp 1", pend_valid);
        end
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if (pc !== 32'h3000 || pend_valid !== 1'b0 || redirect !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async got pc=%h pv=%b rd=%b exp 3000 0 0",
                     pc, pend_valid, redirect);
        end
        @(negedge clk);
        reset = 1'b1;
        clear_in();
        step();
        checks++;
        if (pc !== 32'h3004 || redirect !== 1'b0) begin
            errors++;
            $display("FAIL midrst_discard got pc=%h rd=%b exp 3004 0", pc, redirect);
        end
    endtask

    task automatic test_random();
        logic [31:0] vals [4];
        vals[0] = 32'd0;
        vals[1] = 32'd5;
        vals[2] = 32'hFFFF_FFF0;
        vals[3] = 32'h7FFF_FFFF;
        for (int i = 0; i < 400; i++) begin
            stall    = ($urandom_range(0, 9) < 3);
            exc_req  = ($urandom_range(0, 39) == 0);
            eret_req = ($urandom_range(0, 29) == 0);
            epc      = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0)
                epc[1:0] = 2'($urandom_range(1, 3));
            br_a     = vals[$urandom_range(0, 3)];
            br_b     = vals[$urandom_range(0, 3)];
            imm16    = 16'($urandom);
            imm26    = 26'($urandom);
            pc4_d    = $urandom & 32'hFFFF_FFFC;
            jmp_op   = 2'd0;
            br_op    = 3'd0;
            case ($urandom_range(0, 9))
                0: jmp_op = 2'd1;
                1: begin
                    jmp_op = 2'd2;
                    br_a = $urandom & 32'hFFFF_FFFC;
                    if ($urandom_range(0, 3) == 0)
                        br_a[1:0] = 2'($urandom_range(1, 3));
                end
                2: jmp_op = 2'd3;
                3, 4, 5, 6: br_op = 3'($urandom);
                default: ;
            endcase
            step();
            checks++;
            if (pc !== m_pc || pc4 !== m_pc + 32'd4 || redirect !== m_rd ||
                pend_valid !== m_pv || adel_pc !== m_ad) begin
                errors++;
                $display("FAIL rand_%0d got pc=%h pc4=%h rd=%b pv=%b ad=%b exp pc=%h rd=%b pv=%b ad=%b",
                         i, pc, pc4, redirect, pend_valid, adel_pc,
                         m_pc, m_rd, m_pv, m_ad);
            end
        end
        clear_in();
    endtask

    initial begin
        test_reset();
        test_beq();
        test_stall_branch();
        test_exc_eret();
        test_jr_wrap();
        test_align();
        test_reset_mid_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-PC/PC-register unit for the 5-stage MIPS pipeline, feeding the F-stage instruction memory address.
- Generalises the earlier next-PC block with:
  - six conditional branch types resolved in D
  - j/jal and jr/jalr
  - exception entry and eret
  - a one-entry pending-redirect buffer, so a redirect resolved while F is stalled is not lost

Parameters:
- ADDR_W, 32, PC width; legal range 32..64.
- RESET_VEC, 32'h0000_3000, PC value on reset.
- EXC_VEC, 32'h0000_4180, exception handler entry address.
- JIDX_W, 26, jump index width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- stall  in  1  hold F stage (hazard unit)
- br_op  in  3  0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 reserved (treated as none)
- jmp_op  in  2  0 none, 1 j/jal, 2 jr/jalr, 3 reserved (treated as none)
- br_a  in  32  forwarded rs value in D
- br_b  in  32  forwarded rt value in D
- imm16  in  16  branch offset
- imm26  in  JIDX_W  jump index
- pc4_d  in  ADDR_W  PC+4 of the instruction in D
- exc_req  in  1  exception taken (from M/CP0)
- eret_req  in  1  eret taken
- epc  in  ADDR_W  return address for eret
- pc  out  ADDR_W  current fetch address
- pc4  out  ADDR_W  pc+4
- redirect  out  1  one-cycle pulse: pc was loaded from a non-sequential source this edge
- pend_valid  out  1  pending-redirect buffer occupied

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_VEC, pend_valid=0, redirect=0
  - Pending target cleared to 0.
- Branch conditions use signed 32-bit compares:
  - beq: a==b
  - bne: a!=b
  - blez: a<=0
  - bgtz: a>0
  - bltz: a<0
  - bgez: a>=0
- Targets, all mod 2^ADDR_W:
  - Branch target = pc4_d + (sext(imm16)<<2).
  - j target = {pc4_d[ADDR_W-1:JIDX_W+2], imm26, 2'b00}.
  - jr target = br_a, zero-extended to ADDR_W.
- ctl_hit = taken branch, or jmp_op in {1,2}.
- Per-edge priority, highest first:
  1. exc_req: pc<=EXC_VEC; pend_valid<=0; ignores stall.
  2. eret_req: pc<=epc; pend_valid<=0; ignores stall.
  3. stall=1:
     - pc holds.
     - If ctl_hit: latch target, pend_valid<=1. A newer ctl_hit overwrites the buffered target.
  4. stall=0, ctl_hit: pc<=target; pend_valid<=0.
  5. stall=0, pend_valid=1: pc<=pending target; pend_valid<=0.
  6. Otherwise: pc<=pc+4, wrapping at 2^ADDR_W.
- redirect=1 for exactly the cycle after an edge taking rules 1, 2, 4 or 5; 0 otherwise.
- No delay slot handling in this block; pc4_d supplied by D-stage register.
- pc4 is combinational pc+4.
- Reset asserted mid-stall discards the pending target.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - A jr/eret target with bits[1:0]!=0 is not loaded; pc<=EXC_VEC instead.
  - Extra output adel_pc pulses 1 cycle.
  - This check has rule-2 priority.
- Undefined:
  - Targets loaded unmodified.
  - No adel_pc port.

Decomposition:
- Shared package pc_pkg holds:
  - br_op/jmp_op encodings as localparams
  - RESET_VEC/EXC_VEC defaults
  - ADDR_W default
- Sub-module br_cmp: pure combinational branch-condition evaluator (br_op, br_a, br_b -> taken), reused by the hazard unit.
- Target muxing and the pending buffer stay in pc_sequencer.

Test Plan:
- Reset:
  - Release reset with no control ops -> pc=0x3000, then 0x3004, 0x3008 on successive edges; redirect=0.
- Taken beq:
  - br_op=1, a=b=5, pc4_d=0x3008, imm16=0xFFFE -> next pc=0x3000, redirect=1 one cycle.
- Branch during stall:
  - stall=1 for 3 cycles with bgtz, a=1, imm16=0x0004, pc4_d=0x3010, asserted in cycle 1 only -> pc held, pend_valid=1.
  - On release -> pc=0x3020, pend_valid=0.
- Exception beats stall and pending:
  - pend_valid=1, stall=1, exc_req=1 -> pc=0x4180, pend_valid=0.
  - Then eret_req=1, epc=0x3044 -> pc=0x3044.
- jr and wrap:
  - jmp_op=2, br_a=0xFFFF_FFFC -> pc=0xFFFF_FFFC.
  - Next sequential edge -> pc=0x0000_0000.
- PC_ALIGN_CHECK_EN defined:
  - jr with br_a=0x3002 -> pc=0x4180, adel_pc=1 one cycle.
  - Undefined build, same stimulus -> pc=0x3002.
